// File: rtl/adc_uart_pkg.sv
// Shared types and helpers for the ADC-to-UART frame packer.
//   state_t       : byte-serialiser FSM states
//   bytes_per_ch  : bytes needed to carry one channel sample
//   HEADER_BYTE_DEF : default frame marker byte
package adc_uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SEND    = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4
    } state_t;

    localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;

    // ceil(data_w / 8)
    function automatic int unsigned bytes_per_ch(input int unsigned data_w);
        return (data_w + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock frame FIFO with registered read data.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en/wr_data : push a word (accepted when not full, or when full with a pop in the same cycle)
//   rd_en      : pop; rd_data is updated on the following edge and holds until the next pop
//   full/empty/level : registered occupancy, level in 0..DEPTH
module sync_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;
    logic [LVL_W-1:0] level_d;

    // A pop frees the slot a simultaneous write lands in, so full+pop still accepts
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign level_d = level + LVL_W'(do_wr) - LVL_W'(do_rd);

    // Storage array: no reset needed, occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy flags and read register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
            level   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                rd_data <= mem[rd_ptr];
            end
            level <= level_d;
            full  <= (level_d == LVL_W'(DEPTH));
            empty <= (level_d == '0);
        end
    end

endmodule

// File: rtl/adc_uart_packer.sv
// Buffers multi-channel ADC frames and serialises them byte by byte into a
// start/busy UART transmitter, optionally prefixing each frame with a header.
//   clk, rst_n  : clock, asynchronous active-low reset
//   adc_data    : NUM_CH samples, ch k at [k*DATA_W +: DATA_W]
//   adc_valid   : 1-cycle strobe qualifying adc_data
//   tx_data     : byte to UART, updated only when a byte is loaded
//   tx_start    : 1-cycle pulse requesting transmission of tx_data
//   tx_busy     : UART busy, same clock domain
//   overflow    : 1-cycle pulse when a frame is dropped on a full FIFO
//   drop_cnt    : saturating dropped-frame count
//   fifo_level  : frames currently buffered
module adc_uart_packer
    import adc_uart_pkg::*;
#(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned HEADER_EN   = 1,
    parameter logic [7:0]  HEADER_BYTE = HEADER_BYTE_DEF,
    parameter int unsigned MSB_FIRST   = 0,
    parameter int unsigned BUSY_TO     = 1023
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*DATA_W-1:0]     adc_data,
    input  logic                         adc_valid,
    output logic [7:0]                   tx_data,
    output logic                         tx_start,
    input  logic                         tx_busy,
    output logic                         overflow,
    output logic [15:0]                  drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int unsigned BPC         = bytes_per_ch(DATA_W);
    localparam int unsigned PAD_W       = BPC * 8;
    localparam int unsigned FRAME_W     = NUM_CH * DATA_W;
    localparam int unsigned HDR         = (HEADER_EN != 0) ? 1 : 0;
    localparam int unsigned FRAME_BYTES = HDR + NUM_CH * BPC;
    localparam int unsigned IDX_W       = $clog2(FRAME_BYTES) + 1;
    localparam int unsigned NSLOT       = 1 << IDX_W;
    localparam int unsigned TO_W        = $clog2(BUSY_TO + 1) + 1;

    state_t               state_q;
    state_t               state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     idx_d;
    logic [TO_W-1:0]      to_q;
    logic [TO_W-1:0]      to_d;
    logic [7:0]           tx_data_d;
    logic                 tx_start_d;
    logic                 busy_q;
    logic                 busy_fall;
    logic                 pop_c;
    logic                 drop_c;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FRAME_W-1:0]   frame;
    logic [NSLOT-1:0][7:0] byte_arr;

    // Frame buffer; its read register holds the popped frame for the whole
    // transmission since no other pop can happen until the FSM is back in IDLE.
    sync_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (adc_valid),
        .wr_data (adc_data),
        .rd_en   (pop_c),
        .rd_data (frame),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Byte map of the current frame: header, then each channel zero-padded
    // to whole bytes; slots past the frame end read as zero.
    if (HDR != 0) begin : g_hdr
        assign byte_arr[0] = HEADER_BYTE;
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [PAD_W-1:0] padded;
        assign padded = PAD_W'(frame[ch*DATA_W +: DATA_W]);
        for (genvar b = 0; b < BPC; b++) begin : g_b
            localparam int unsigned SRC = (MSB_FIRST != 0) ? (BPC - 1 - b) : b;
            assign byte_arr[HDR + ch*BPC + b] = padded[SRC*8 +: 8];
        end
    end

    for (genvar i = FRAME_BYTES; i < NSLOT; i++) begin : g_pad
        assign byte_arr[i] = 8'h00;
    end

    assign busy_fall = busy_q && !tx_busy;
    assign drop_c    = adc_valid && fifo_full && !pop_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            to_q     <= '0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            to_q     <= to_d;
            tx_data  <= tx_data_d;
            tx_start <= tx_start_d;
            busy_q   <= tx_busy;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        to_d       = to_q;
        tx_data_d  = tx_data;
        tx_start_d = 1'b0;
        pop_c      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    pop_c   = 1'b1;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // tx_data and tx_start register together so the pulse sees the new byte
                tx_data_d  = byte_arr[idx_q];
                tx_start_d = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                to_d    = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (to_q == TO_W'(BUSY_TO)) begin
                    // UART never acknowledged: treat the byte as sent
                    if (idx_q == IDX_W'(FRAME_BYTES - 1)) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = LOAD;
                    end
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            WAIT_LO: begin
                if (busy_fall) begin
                    if (idx_q == IDX_W'(FRAME_BYTES - 1)) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = LOAD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Drop pulse and saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= 16'h0000;
        end else begin
            overflow <= drop_c;
            if (drop_c && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_adc_uart_packer.sv
// Scoreboard bench for adc_uart_packer: stimulus pushes expected bytes,
// monitors pop and compare on every tx_start.
module tb_adc_uart_packer;

    localparam int unsigned BUSY_TO = 1023;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n;

    // Instance A: default configuration
    logic [23:0] adc_data;
    logic        adc_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [4:0]  fifo_level;

    // Instance B: one 16-bit channel, no header, MSB first
    logic [15:0] adc_data_b;
    logic        adc_valid_b;
    logic [7:0]  tx_data_b;
    logic        tx_start_b;
    logic        tx_busy_b;
    logic        overflow_b;
    logic [15:0] drop_cnt_b;
    logic [4:0]  fifo_level_b;

    adc_uart_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level)
    );

    adc_uart_packer #(
        .DATA_W     (16),
        .NUM_CH     (1),
        .FIFO_DEPTH (16),
        .HEADER_EN  (0),
        .MSB_FIRST  (1),
        .BUSY_TO    (BUSY_TO)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .adc_data   (adc_data_b),
        .adc_valid  (adc_valid_b),
        .tx_data    (tx_data_b),
        .tx_start   (tx_start_b),
        .tx_busy    (tx_busy_b),
        .overflow   (overflow_b),
        .drop_cnt   (drop_cnt_b),
        .fifo_level (fifo_level_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Scoreboards
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         start_cyc[$];
    int         starts_a = 0;
    int         starts_b = 0;
    int         ovf_cnt  = 0;

    // UART model A: busy for busy_len cycles after each start
    int busy_len   = 10;
    bit no_busy    = 1'b0;
    bit force_busy = 1'b0;
    int bcnt_a     = 0;
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) bcnt_a = 0;
            else if (tx_start && !no_busy) bcnt_a = busy_len;
            else if (bcnt_a > 0) bcnt_a--;
            tx_busy = force_busy || (bcnt_a > 0);
        end
    end

    // UART model B: fixed 3-cycle busy
    int bcnt_b = 0;
    initial begin
        tx_busy_b = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) bcnt_b = 0;
            else if (tx_start_b) bcnt_b = 3;
            else if (bcnt_b > 0) bcnt_b--;
            tx_busy_b = (bcnt_b > 0);
        end
    end

    // Monitor A
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (overflow) ovf_cnt++;
            if (rst_n && tx_start) begin
                starts_a++;
                start_cyc.push_back(cyc);
                if (qa.size() == 0) begin
                    check("a_unexpected_start", 32'(tx_start), 32'(0));
                end else begin
                    e = qa.pop_front();
                    check("a_tx_data", 32'(tx_data), 32'(e));
                end
            end
        end
    end

    // Monitor B
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && tx_start_b) begin
                starts_b++;
                if (qb.size() == 0) begin
                    check("b_unexpected_start", 32'(tx_start_b), 32'(0));
                end else begin
                    e = qb.pop_front();
                    check("b_tx_data", 32'(tx_data_b), 32'(e));
                end
            end
        end
    end

    function automatic void push_frame_a(input logic [11:0] c0, input logic [11:0] c1);
        qa.push_back(8'hA5);
        qa.push_back(c0[7:0]);
        qa.push_back({4'h0, c0[11:8]});
        qa.push_back(c1[7:0]);
        qa.push_back({4'h0, c1[11:8]});
    endfunction

    // Issue one frame to A; returns the cycle adc_valid was sampled
    task automatic send_a(input logic [11:0] c0, input logic [11:0] c1, output int n0);
        @(negedge clk);
        adc_data  = {c1, c0};
        adc_valid = 1'b1;
        n0        = cyc;
        @(negedge clk);
        adc_valid = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] s);
        @(negedge clk);
        adc_data_b  = s;
        adc_valid_b = 1'b1;
        @(negedge clk);
        adc_valid_b = 1'b0;
    endtask

    task automatic latency_a(input string name, input int n0);
        int n = 0;
        while (!tx_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(cyc - n0), 32'(3));
    endtask

    task automatic wait_starts_a(input string name, input int target, input int budget);
        int n = 0;
        while (starts_a < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 32'(starts_a), 32'(target));
    endtask

    task automatic wait_starts_b(input string name, input int target, input int budget);
        int n = 0;
        while (starts_b < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 32'(starts_b), 32'(target));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0;
        int          n;
        logic [11:0] c0;
        logic [11:0] c1;

        rst_n       = 1'b0;
        adc_data    = '0;
        adc_valid   = 1'b0;
        adc_data_b  = '0;
        adc_valid_b = 1'b0;
        idle_cycles(3);
        #1;
        check("reset_tx_data",    32'(tx_data),    32'(0));
        check("reset_tx_start",   32'(tx_start),   32'(0));
        check("reset_overflow",   32'(overflow),   32'(0));
        check("reset_drop_cnt",   32'(drop_cnt),   32'(0));
        check("reset_fifo_level", 32'(fifo_level), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // Single frame, header + two 12-bit channels, LSB first
        qa.push_back(8'hA5);
        qa.push_back(8'hBC);
        qa.push_back(8'h0A);
        qa.push_back(8'h23);
        qa.push_back(8'h01);
        send_a(12'hABC, 12'h123, n0);
        latency_a("t1_latency", n0);
        wait_starts_a("t1_pulses", 5, 500);
        idle_cycles(30);
        check("t1_pulse_total", 32'(starts_a), 32'(5));
        check("t1_queue_empty", 32'(qa.size()), 32'(0));

        // MSB-first 16-bit single channel without header
        qb.push_back(8'hBE);
        qb.push_back(8'hEF);
        send_b(16'hBEEF);
        qb.push_back(8'h12);
        qb.push_back(8'h34);
        send_b(16'h1234);
        wait_starts_b("t2_pulses", 4, 200);
        idle_cycles(10);
        check("t2_queue_empty", 32'(qb.size()), 32'(0));

        // Burst of 20 into a stalled UART: 16 kept, 4 dropped
        busy_len   = 200;
        force_busy = 1'b1;
        idle_cycles(2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            c0        = 12'(32'h100 + i);
            c1        = 12'(32'hE00 + 3 * i);
            adc_data  = {c1, c0};
            adc_valid = 1'b1;
            if (i < 16) push_frame_a(c0, c1);
        end
        @(negedge clk);
        adc_valid = 1'b0;
        idle_cycles(3);
        check("t3_overflow_pulses", 32'(ovf_cnt),    32'(4));
        check("t3_drop_cnt",        32'(drop_cnt),   32'(4));
        check("t3_fifo_level_full", 32'(fifo_level), 32'(16));

        // Release the UART, refill to 16 once the first frame is popped
        force_busy = 1'b0;
        n = 0;
        while (fifo_level != 5'd15 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t3_level_after_pop", 32'(fifo_level), 32'(15));
        c0 = 12'h777;
        c1 = 12'h888;
        push_frame_a(c0, c1);
        send_a(c0, c1, n0);
        #1;
        check("t3_level_refilled", 32'(fifo_level), 32'(16));

        // Write on the exact cycle of a pop while full
        wait_starts_a("t4_first_frame_done", 10, 3000);
        n = 0;
        while (tx_busy && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t4_busy_fell", 32'(tx_busy), 32'(0));
        @(negedge clk);
        c0        = 12'hC3C;
        c1        = 12'h3C3;
        adc_data  = {c1, c0};
        adc_valid = 1'b1;
        push_frame_a(c0, c1);
        @(negedge clk);
        adc_valid = 1'b0;
        #1;
        check("t4_no_overflow",  32'(overflow),   32'(0));
        check("t4_level_stays",  32'(fifo_level), 32'(16));
        idle_cycles(2);
        check("t4_drop_cnt",     32'(drop_cnt),   32'(4));
        check("t4_ovf_total",    32'(ovf_cnt),    32'(4));

        wait_starts_a("t3_all_sent", 95, 25000);
        idle_cycles(220);
        check("t3_queue_empty", 32'(qa.size()),   32'(0));
        check("t3_fifo_empty",  32'(fifo_level), 32'(0));

        // UART never raises busy: every byte times out
        no_busy = 1'b1;
        idle_cycles(2);
        push_frame_a(12'h456, 12'h789);
        send_a(12'h456, 12'h789, n0);
        wait_starts_a("t5_pulses", 100, 6000);
        for (int k = 96; k < 100; k++) begin
            check("t5_timeout_spacing", 32'(start_cyc[k] - start_cyc[k-1]), 32'(BUSY_TO + 3));
        end
        idle_cycles(BUSY_TO + 20);
        no_busy  = 1'b0;
        busy_len = 10;
        idle_cycles(2);

        // Back in IDLE; reset in the middle of the third byte
        push_frame_a(12'h5A3, 12'h0C7);
        send_a(12'h5A3, 12'h0C7, n0);
        latency_a("t6_latency_after_timeout", n0);
        wait_starts_a("t6_third_byte", 103, 200);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_tx_data",    32'(tx_data),    32'(0));
        check("t6_rst_tx_start",   32'(tx_start),   32'(0));
        check("t6_rst_drop_cnt",   32'(drop_cnt),   32'(0));
        check("t6_rst_overflow",   32'(overflow),   32'(0));
        check("t6_rst_fifo_level", 32'(fifo_level), 32'(0));
        qa.delete();
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(2);
        push_frame_a(12'hFED, 12'h321);
        send_a(12'hFED, 12'h321, n0);
        latency_a("t6_latency_post_reset", n0);
        wait_starts_a("t6_new_frame", 108, 300);
        idle_cycles(30);
        check("t6_queue_empty", 32'(qa.size()), 32'(0));
        check("end_b_queue_empty", 32'(qb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
